// File: rtl/salu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : salu_pkg
// Purpose  : Definitions shared by the scalar ALU and its resolve stage:
//            4-bit ALU op encodings, default datapath widths and the
//            writeback entry record carried through the skid buffer.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package salu_pkg;

  localparam int unsigned c_DATA_WIDTH     = 32;
  localparam int unsigned c_REG_ADDR_WIDTH = 5;

  // ALU op encodings; 1010..1111 are the conditional branch compares.
  localparam logic [3:0] c_OP_ADD  = 4'b0000;
  localparam logic [3:0] c_OP_SUB  = 4'b0001;
  localparam logic [3:0] c_OP_AND  = 4'b0010;
  localparam logic [3:0] c_OP_OR   = 4'b0011;
  localparam logic [3:0] c_OP_XOR  = 4'b0100;
  localparam logic [3:0] c_OP_SLL  = 4'b0101;
  localparam logic [3:0] c_OP_SRL  = 4'b0110;
  localparam logic [3:0] c_OP_SRA  = 4'b0111;
  localparam logic [3:0] c_OP_SLT  = 4'b1000;
  localparam logic [3:0] c_OP_SLTU = 4'b1001;
  localparam logic [3:0] c_OP_BEQ  = 4'b1010;
  localparam logic [3:0] c_OP_BNE  = 4'b1011;
  localparam logic [3:0] c_OP_BLT  = 4'b1100;
  localparam logic [3:0] c_OP_BGE  = 4'b1101;
  localparam logic [3:0] c_OP_BLTU = 4'b1110;
  localparam logic [3:0] c_OP_BGEU = 4'b1111;

  typedef struct packed {
    logic [c_DATA_WIDTH-1:0]     data;
    logic [c_REG_ADDR_WIDTH-1:0] addr;
    logic                        we;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/salu_resolve_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : salu_resolve_stage_if
// Purpose  : Bundles the upstream (ALU side), writeback and redirect signals
//            of the resolve stage.
// Modports : master - environment: drives ALU entry, flush and ready_i;
//                     observes ready_o, writeback and redirect outputs.
//            slave  - the resolve stage itself.
// Revision : 1.0 - initial release
// ============================================================================
interface salu_resolve_stage_if
  import salu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = c_DATA_WIDTH,
  parameter int unsigned REG_ADDR_WIDTH = c_REG_ADDR_WIDTH
);

  // Upstream (ALU) side
  logic                      valid_i;
  logic                      ready_o;
  logic [DATA_WIDTH-1:0]     alu_res_i;
  logic                      zero_flag_i;
  logic [3:0]                alu_op_i;
  logic                      is_branch_i;
  logic [DATA_WIDTH-1:0]     pc_i;
  logic [DATA_WIDTH-1:0]     imm_i;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_i;
  logic                      rd_we_i;
  logic                      flush_i;

  // Writeback side
  logic                      valid_o;
  logic                      ready_i;
  logic [DATA_WIDTH-1:0]     wb_data_o;
  logic [REG_ADDR_WIDTH-1:0] wb_addr_o;
  logic                      wb_we_o;

  // Branch redirect
  logic                      redirect_valid_o;
  logic [DATA_WIDTH-1:0]     redirect_pc_o;

  modport master (
    output valid_i, alu_res_i, zero_flag_i, alu_op_i, is_branch_i,
           pc_i, imm_i, rd_addr_i, rd_we_i, flush_i, ready_i,
    input  ready_o, valid_o, wb_data_o, wb_addr_o, wb_we_o,
           redirect_valid_o, redirect_pc_o
  );

  modport slave (
    input  valid_i, alu_res_i, zero_flag_i, alu_op_i, is_branch_i,
           pc_i, imm_i, rd_addr_i, rd_we_i, flush_i, ready_i,
    output ready_o, valid_o, wb_data_o, wb_addr_o, wb_we_o,
           redirect_valid_o, redirect_pc_o
  );

endinterface
`default_nettype wire

// File: rtl/salu_branch_cond.sv
`default_nettype none
// ============================================================================
// Module   : salu_branch_cond
// Purpose  : Combinational taken/not-taken evaluation of a conditional
//            branch from the ALU op, zero flag and result LSB. The ALU puts
//            the signed/unsigned less-than outcome in res[0] for the
//            BLT/BGE/BLTU/BGEU compares.
// Ports    : alu_op_i    - 4-bit ALU op
//            zero_flag_i - ALU zero flag
//            res_lsb_i   - bit 0 of the ALU result
//            taken_o     - branch condition holds
// Revision : 1.0 - initial release
// ============================================================================
module salu_branch_cond
  import salu_pkg::*;
(
  input  logic [3:0] alu_op_i,
  input  logic       zero_flag_i,
  input  logic       res_lsb_i,
  output logic       taken_o
);

  always_comb begin
    taken_o = 1'b0;
    case (alu_op_i)
      c_OP_BEQ:             taken_o = zero_flag_i;
      c_OP_BNE:             taken_o = ~zero_flag_i;
      c_OP_BLT, c_OP_BLTU:  taken_o = res_lsb_i;
      c_OP_BGE, c_OP_BGEU:  taken_o = ~res_lsb_i;
      // Non-compare ops flagged as branches are never taken.
      default:              taken_o = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/salu_resolve_stage.sv
`default_nettype none
// ============================================================================
// Module   : salu_resolve_stage
// Purpose  : Stage after the scalar ALU. Resolves conditional branches into a
//            one-cycle redirect pulse with a PC+imm target, and passes
//            non-branch results to the register-file writeback port through
//            a two-entry skid buffer (OUT register + SKID register).
// Ports    : clk   - clock, rising edge
//            rst_n - asynchronous active-low reset
//            bus   - salu_resolve_stage_if.slave (ALU entry, flush,
//                    writeback handshake, redirect)
//            perf_taken_o / perf_stall_o - performance counters, present
//                    only when SALU_RESOLVE_PERF_EN is defined
// Config   : SALU_RESOLVE_PERF_EN - adds the taken-branch and writeback
//            stall counters
// Revision : 1.0 - initial release
// ============================================================================
module salu_resolve_stage
  import salu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = c_DATA_WIDTH,
  parameter int unsigned REG_ADDR_WIDTH = c_REG_ADDR_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  salu_resolve_stage_if.slave  bus
`ifdef SALU_RESOLVE_PERF_EN
  ,
  output logic [31:0]          perf_taken_o,
  output logic [31:0]          perf_stall_o
`endif
);

  // The buffered entry record is shared with the ALU package, so the stage
  // widths must match the package widths.
  if ((DATA_WIDTH != c_DATA_WIDTH) || (REG_ADDR_WIDTH != c_REG_ADDR_WIDTH))
  begin : g_width_check
    $error("salu_resolve_stage: widths must match salu_pkg");
  end

  wb_entry_t             out_q, out_d;
  wb_entry_t             skid_q, skid_d;
  logic                  out_v_q, out_v_d;
  logic                  skid_v_q, skid_v_d;
  logic                  redir_v_q, redir_v_d;
  logic [DATA_WIDTH-1:0] redir_pc_q, redir_pc_d;

  logic      taken;
  logic      accept;
  logic      enq;
  logic      deq;
  logic      redir_fire;
  wb_entry_t in_entry;

  salu_branch_cond u_branch_cond (
    .alu_op_i    (bus.alu_op_i),
    .zero_flag_i (bus.zero_flag_i),
    .res_lsb_i   (bus.alu_res_i[0]),
    .taken_o     (taken)
  );

  // ready_o comes straight from the SKID valid flop, so it is registered.
  assign accept     = bus.valid_i && !skid_v_q && !bus.flush_i;
  assign enq        = accept && !bus.is_branch_i;
  assign deq        = out_v_q && bus.ready_i;
  assign redir_fire = accept && bus.is_branch_i && taken;

  // Writes to x0 are kept in order but never enable the register file.
  assign in_entry.data = bus.alu_res_i;
  assign in_entry.addr = bus.rd_addr_i;
  assign in_entry.we   = bus.rd_we_i && (bus.rd_addr_i != '0);

  always_comb begin
    out_d      = out_q;
    skid_d     = skid_q;
    out_v_d    = out_v_q;
    skid_v_d   = skid_v_q;
    redir_v_d  = redir_fire;
    redir_pc_d = redir_pc_q;

    if (redir_fire) begin
      redir_pc_d = bus.pc_i + bus.imm_i;
    end

    if (bus.flush_i) begin
      out_v_d  = 1'b0;
      skid_v_d = 1'b0;
    end else if (skid_v_q) begin
      // SKID full means ready_o is low, so no enqueue can coincide here.
      if (deq) begin
        out_d    = skid_q;
        skid_v_d = 1'b0;
      end
    end else if (enq) begin
      if (!out_v_q || bus.ready_i) begin
        out_d   = in_entry;
        out_v_d = 1'b1;
      end else begin
        skid_d   = in_entry;
        skid_v_d = 1'b1;
      end
    end else if (deq) begin
      out_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_v_q    <= 1'b0;
      skid_v_q   <= 1'b0;
      redir_v_q  <= 1'b0;
      redir_pc_q <= '0;
    end else begin
      out_q      <= out_d;
      skid_q     <= skid_d;
      out_v_q    <= out_v_d;
      skid_v_q   <= skid_v_d;
      redir_v_q  <= redir_v_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  assign bus.ready_o          = !skid_v_q;
  assign bus.valid_o          = out_v_q;
  assign bus.wb_data_o        = out_q.data;
  assign bus.wb_addr_o        = out_q.addr;
  assign bus.wb_we_o          = out_q.we;
  assign bus.redirect_valid_o = redir_v_q;
  assign bus.redirect_pc_o    = redir_pc_q;

`ifdef SALU_RESOLVE_PERF_EN
  logic [31:0] perf_taken_q, perf_taken_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Counters ignore flush; a flushed branch never reaches redir_fire.
  always_comb begin
    perf_taken_d = perf_taken_q;
    perf_stall_d = perf_stall_q;
    if (redir_fire) begin
      perf_taken_d = perf_taken_q + 32'd1;
    end
    if (out_v_q && !bus.ready_i) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_taken_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_taken_q <= perf_taken_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_taken_o = perf_taken_q;
  assign perf_stall_o = perf_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_salu_resolve_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_salu_resolve_stage
// Purpose  : Self-checking bench for salu_resolve_stage: a table of single
//            entries (branches and writebacks) plus hand-written sequences
//            for skid fill/drain, flush and mid-operation reset.
// Config   : SALU_RESOLVE_PERF_EN - also checks the performance counters
// Revision : 1.0 - initial release
// ============================================================================
module tb_salu_resolve_stage;
  import salu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  salu_resolve_stage_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

`ifdef SALU_RESOLVE_PERF_EN
  logic [31:0] perf_taken;
  logic [31:0] perf_stall;
`endif

  salu_resolve_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef SALU_RESOLVE_PERF_EN
    ,
    .perf_taken_o (perf_taken),
    .perf_stall_o (perf_stall)
`endif
  );

  typedef struct {
    logic        br;
    logic [3:0]  op;
    logic        z;
    logic [31:0] res;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        we;
    logic        exp_red;
    logic [31:0] exp_tgt;
    logic        exp_v;
    logic [31:0] exp_data;
    logic [4:0]  exp_addr;
    logic        exp_we;
  } vec_t;

  localparam int c_NVEC = 12;
  vec_t vecs [c_NVEC];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.valid_i     = 1'b0;
    bus.alu_res_i   = '0;
    bus.zero_flag_i = 1'b0;
    bus.alu_op_i    = c_OP_ADD;
    bus.is_branch_i = 1'b0;
    bus.pc_i        = '0;
    bus.imm_i       = '0;
    bus.rd_addr_i   = '0;
    bus.rd_we_i     = 1'b0;
    bus.flush_i     = 1'b0;
  endtask

  task automatic drive_wb(input logic [31:0] data, input logic [4:0] rd);
    bus.valid_i     = 1'b1;
    bus.is_branch_i = 1'b0;
    bus.alu_op_i    = c_OP_ADD;
    bus.alu_res_i   = data;
    bus.rd_addr_i   = rd;
    bus.rd_we_i     = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_rpc;
  int          exp_taken;
  logic [31:0] stall0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          br  op         z  res           pc            imm           rd  we red tgt           v  data          addr we
    vecs[0]  = '{1, c_OP_BEQ,  1, 32'h0,        32'h100,      32'hFFFFFFF0, 0,  0, 1, 32'h000000F0, 0, 32'h0,        0, 0};
    vecs[1]  = '{1, c_OP_BEQ,  0, 32'h0,        32'h200,      32'h10,       0,  0, 0, 32'h0,        0, 32'h0,        0, 0};
    vecs[2]  = '{1, c_OP_BNE,  0, 32'h0,        32'h200,      32'h10,       0,  0, 1, 32'h210,      0, 32'h0,        0, 0};
    vecs[3]  = '{1, c_OP_BLT,  0, 32'h1,        32'h300,      32'h8,        0,  0, 1, 32'h308,      0, 32'h0,        0, 0};
    vecs[4]  = '{1, c_OP_BGE,  0, 32'h1,        32'h400,      32'h4,        0,  0, 0, 32'h0,        0, 32'h0,        0, 0};
    vecs[5]  = '{1, c_OP_BGEU, 0, 32'h2,        32'hFFFFFFFC, 32'h8,        0,  0, 1, 32'h00000004, 0, 32'h0,        0, 0};
    vecs[6]  = '{1, c_OP_BLTU, 0, 32'h0,        32'h500,      32'h4,        0,  0, 0, 32'h0,        0, 32'h0,        0, 0};
    vecs[7]  = '{1, c_OP_ADD,  1, 32'h1,        32'h600,      32'h4,        0,  0, 0, 32'h0,        0, 32'h0,        0, 0};
    vecs[8]  = '{0, c_OP_ADD,  0, 32'h1234,     32'h0,        32'h0,        5,  1, 0, 32'h0,        1, 32'h1234,     5, 1};
    vecs[9]  = '{0, c_OP_ADD,  0, 32'hDEADBEEF, 32'h0,        32'h0,        0,  1, 0, 32'h0,        1, 32'hDEADBEEF, 0, 0};
    vecs[10] = '{0, c_OP_SUB,  0, 32'hA5A5,     32'h0,        32'h0,        31, 0, 0, 32'h0,        1, 32'hA5A5,     31, 0};
    vecs[11] = '{0, c_OP_BEQ,  1, 32'h77,       32'h700,      32'h40,       3,  1, 0, 32'h0,        1, 32'h77,       3, 1};

    idle_inputs();
    bus.ready_i = 1'b1;
    exp_rpc     = 32'h0;
    exp_taken   = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("reset ready_o",          {31'b0, bus.ready_o},          32'd1);
    chk("reset valid_o",          {31'b0, bus.valid_o},          32'd0);
    chk("reset wb_data_o",        bus.wb_data_o,                 32'd0);
    chk("reset wb_addr_o",        {27'b0, bus.wb_addr_o},        32'd0);
    chk("reset wb_we_o",          {31'b0, bus.wb_we_o},          32'd0);
    chk("reset redirect_valid_o", {31'b0, bus.redirect_valid_o}, 32'd0);
    chk("reset redirect_pc_o",    bus.redirect_pc_o,             32'd0);
`ifdef SALU_RESOLVE_PERF_EN
    chk("reset perf_taken", perf_taken, 32'd0);
    chk("reset perf_stall", perf_stall, 32'd0);
`endif
    @(posedge clk);
    #1;

    // Single-entry table, writeback always ready
    for (int i = 0; i < c_NVEC; i++) begin
      bus.valid_i     = 1'b1;
      bus.is_branch_i = vecs[i].br;
      bus.alu_op_i    = vecs[i].op;
      bus.zero_flag_i = vecs[i].z;
      bus.alu_res_i   = vecs[i].res;
      bus.pc_i        = vecs[i].pc;
      bus.imm_i       = vecs[i].imm;
      bus.rd_addr_i   = vecs[i].rd;
      bus.rd_we_i     = vecs[i].we;
      tick();
      idle_inputs();
      if (vecs[i].exp_red) begin
        exp_rpc = vecs[i].exp_tgt;
        exp_taken++;
      end
      chk($sformatf("vec%0d redirect_valid", i), {31'b0, bus.redirect_valid_o}, {31'b0, vecs[i].exp_red});
      chk($sformatf("vec%0d redirect_pc", i),    bus.redirect_pc_o,             exp_rpc);
      chk($sformatf("vec%0d valid_o", i),        {31'b0, bus.valid_o},          {31'b0, vecs[i].exp_v});
      if (vecs[i].exp_v) begin
        chk($sformatf("vec%0d wb_data", i), bus.wb_data_o,          vecs[i].exp_data);
        chk($sformatf("vec%0d wb_addr", i), {27'b0, bus.wb_addr_o}, {27'b0, vecs[i].exp_addr});
        chk($sformatf("vec%0d wb_we", i),   {31'b0, bus.wb_we_o},   {31'b0, vecs[i].exp_we});
      end
      tick();
      chk($sformatf("vec%0d redirect pulse end", i), {31'b0, bus.redirect_valid_o}, 32'd0);
      chk($sformatf("vec%0d drained", i),            {31'b0, bus.valid_o},          32'd0);
    end
`ifdef SALU_RESOLVE_PERF_EN
    chk("perf_taken after table", perf_taken, exp_taken);
    stall0 = perf_stall;
`else
    stall0 = 32'd0;
`endif

    // Skid fill and ordered drain: A, B, C with writeback stalled
    bus.ready_i = 1'b0;
    drive_wb(32'hAAAA0001, 5'd1);
    tick();
    chk("skid A valid_o", {31'b0, bus.valid_o}, 32'd1);
    chk("skid A data",    bus.wb_data_o,        32'hAAAA0001);
    chk("skid A ready_o", {31'b0, bus.ready_o}, 32'd1);
    drive_wb(32'hBBBB0002, 5'd2);
    tick();
    chk("skid B ready_o low", {31'b0, bus.ready_o}, 32'd0);
    chk("skid B OUT holds A", bus.wb_data_o,        32'hAAAA0001);
    drive_wb(32'hCCCC0003, 5'd3);
    tick();
    chk("skid C held ready_o", {31'b0, bus.ready_o}, 32'd0);
    chk("skid stable data",    bus.wb_data_o,        32'hAAAA0001);
    chk("skid stable addr",    {27'b0, bus.wb_addr_o}, 32'd1);
    bus.ready_i = 1'b1;
    tick();
    chk("drain B data",    bus.wb_data_o,          32'hBBBB0002);
    chk("drain B addr",    {27'b0, bus.wb_addr_o}, 32'd2);
    chk("drain ready_o",   {31'b0, bus.ready_o},   32'd1);
    tick();
    idle_inputs();
    chk("drain C valid_o", {31'b0, bus.valid_o},   32'd1);
    chk("drain C data",    bus.wb_data_o,          32'hCCCC0003);
    chk("drain C addr",    {27'b0, bus.wb_addr_o}, 32'd3);
    tick();
    chk("drain empty",     {31'b0, bus.valid_o},   32'd0);
`ifdef SALU_RESOLVE_PERF_EN
    chk("perf_stall delta", perf_stall - stall0, 32'd2);
`endif

    // Full buffer then one-cycle flush
    bus.ready_i = 1'b0;
    drive_wb(32'h11111111, 5'd4);
    tick();
    drive_wb(32'h22222222, 5'd6);
    tick();
    idle_inputs();
    chk("pre-flush ready_o low", {31'b0, bus.ready_o}, 32'd0);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    chk("flush valid_o", {31'b0, bus.valid_o}, 32'd0);
    chk("flush ready_o", {31'b0, bus.ready_o}, 32'd1);

    // Taken BLTU in the flush cycle is dropped
    bus.valid_i     = 1'b1;
    bus.is_branch_i = 1'b1;
    bus.alu_op_i    = c_OP_BLTU;
    bus.alu_res_i   = 32'h1;
    bus.pc_i        = 32'h800;
    bus.imm_i       = 32'h100;
    bus.flush_i     = 1'b1;
    tick();
    idle_inputs();
    chk("flushed BLTU no redirect", {31'b0, bus.redirect_valid_o}, 32'd0);
    chk("flushed BLTU pc held",     bus.redirect_pc_o,             exp_rpc);
    chk("flushed BLTU no entry",    {31'b0, bus.valid_o},          32'd0);
`ifdef SALU_RESOLVE_PERF_EN
    chk("flushed BLTU perf_taken", perf_taken, exp_taken);
`endif

    // Redirect registered before a flush still fires
    bus.valid_i     = 1'b1;
    bus.is_branch_i = 1'b1;
    bus.alu_op_i    = c_OP_BEQ;
    bus.zero_flag_i = 1'b1;
    bus.pc_i        = 32'h1000;
    bus.imm_i       = 32'h20;
    tick();
    idle_inputs();
    exp_rpc = 32'h1020;
    exp_taken++;
    bus.flush_i = 1'b1;
    #1;
    chk("pre-flush redirect fires", {31'b0, bus.redirect_valid_o}, 32'd1);
    chk("pre-flush redirect pc",    bus.redirect_pc_o,             exp_rpc);
    tick();
    bus.flush_i = 1'b0;
    chk("pre-flush redirect ends",  {31'b0, bus.redirect_valid_o}, 32'd0);
`ifdef SALU_RESOLVE_PERF_EN
    chk("perf_taken after flush seq", perf_taken, exp_taken);
`endif

    // Reset mid-operation drops buffered entries immediately
    bus.ready_i = 1'b0;
    drive_wb(32'h33333333, 5'd7);
    tick();
    drive_wb(32'h44444444, 5'd8);
    tick();
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    chk("midreset valid_o",     {31'b0, bus.valid_o}, 32'd0);
    chk("midreset ready_o",     {31'b0, bus.ready_o}, 32'd1);
    chk("midreset wb_data_o",   bus.wb_data_o,        32'd0);
    chk("midreset redirect_pc", bus.redirect_pc_o,    32'd0);
`ifdef SALU_RESOLVE_PERF_EN
    chk("midreset perf_taken", perf_taken, 32'd0);
`endif
    #3 rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
